decoder_n_seq: RTL

DECODER_N_SEQ -- requirements
Module: decoder_n_seq

---
 rtl/decoder_n_seq.sv | 128 ++++++++++++
 1 files changed

// File: rtl/decoder_n_seq.sv
// Registered binary-to-one-hot decoder with latch, pulse and scan modes.
// Optional range_err output enabled by defining DEC_RANGE_ERR_EN.
module decoder_n_seq #(
    parameter int SEL_W    = 2,
    parameter int NUM_OUT  = 4,
    parameter int SCAN_DIV = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic               sel_valid,
    input  logic [SEL_W-1:0]   sel,
    input  logic [1:0]         mode,
    output logic [NUM_OUT-1:0] y,
    output logic               y_valid,
    output logic               scan_wrap
`ifdef DEC_RANGE_ERR_EN
    ,
    output logic               range_err
`endif
);

    typedef enum logic [1:0] {
        MODE_LATCH = 2'b00,
        MODE_PULSE = 2'b01,
        MODE_SCAN  = 2'b10,
        MODE_RSVD  = 2'b11
    } mode_e;

    localparam logic [15:0]      PRE_LAST = 16'(SCAN_DIV - 1);
    localparam logic [SEL_W-1:0] IDX_LAST = SEL_W'(NUM_OUT - 1);
    localparam logic [SEL_W:0]   SEL_LIM  = (SEL_W + 1)'(NUM_OUT);

    mode_e              mode_in, mode_q, mode_d;
    logic [SEL_W-1:0]   idx_q, idx_d;
    logic [15:0]        pre_q, pre_d;
    logic [NUM_OUT-1:0] y_d;
    logic               wrap_d;
    logic               accept, in_range, mode_chg;
`ifdef DEC_RANGE_ERR_EN
    logic               err_d;
`endif

    function automatic logic [NUM_OUT-1:0] onehot(input logic [SEL_W-1:0] i);
        logic [NUM_OUT-1:0] r;
        r = '0;
        for (int unsigned k = 0; k < NUM_OUT; k++)
            if (i == SEL_W'(k)) r[k] = 1'b1;
        return r;
    endfunction

    assign mode_in = mode_e'(mode);

    // State register; mode_q resets to reserved so scan after reset counts as entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q    <= MODE_RSVD;
            idx_q     <= '0;
            pre_q     <= '0;
            y         <= '0;
            y_valid   <= 1'b0;
            scan_wrap <= 1'b0;
`ifdef DEC_RANGE_ERR_EN
            range_err <= 1'b0;
`endif
        end else begin
            mode_q    <= mode_d;
            idx_q     <= idx_d;
            pre_q     <= pre_d;
            y         <= y_d;
            y_valid   <= |y_d;
            scan_wrap <= wrap_d;
`ifdef DEC_RANGE_ERR_EN
            range_err <= err_d;
`endif
        end
    end

    always_comb begin
        accept   = enable & sel_valid;
        in_range = {1'b0, sel} < SEL_LIM;
        mode_chg = mode_in != mode_q;
        mode_d   = mode_q;
        idx_d    = idx_q;
        pre_d    = pre_q;
        y_d      = '0;
        wrap_d   = 1'b0;
`ifdef DEC_RANGE_ERR_EN
        err_d    = accept & ~in_range & (mode_in != MODE_RSVD);
`endif
        // Mode is only tracked while enabled so a change made while disabled
        // is still seen as a mode change once enable returns.
        if (enable) begin
            mode_d = mode_in;
            unique case (mode_in)
                MODE_LATCH: begin
                    if (accept)         y_d = in_range ? onehot(sel) : '0;
                    else if (!mode_chg) y_d = y;
                end
                MODE_PULSE: begin
                    if (accept && in_range) y_d = onehot(sel);
                end
                MODE_SCAN: begin
                    if (accept && in_range) begin
                        idx_d = sel;
                        pre_d = '0;
                    end else if (mode_chg) begin
                        idx_d = '0;
                        pre_d = '0;
                    end else if (pre_q == PRE_LAST) begin
                        pre_d = '0;
                        if (idx_q == IDX_LAST) begin
                            idx_d  = '0;
                            wrap_d = 1'b1;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end else begin
                        pre_d = pre_q + 16'd1;
                    end
                    y_d = onehot(idx_d);
                end
                default: ;
            endcase
        end
    end

endmodule
